// File: rtl/core_wb_arbiter.sv
// Register-file write-port arbiter: merges ALU results with buffered long-latency
// completions and tracks outstanding long-latency destinations in a scoreboard.
module core_wb_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [4:0]                    alu_rd_addr,
  input  logic [31:0]                   alu_rd_data,
  input  logic                          lsu_valid,
  output logic                          lsu_ready,
  input  logic [4:0]                    lsu_rd_addr,
  input  logic [31:0]                   lsu_rd_data,
  input  logic                          issue_valid,
  input  logic                          issue_long,
  input  logic [4:0]                    issue_rd_addr,
  input  logic [4:0]                    rs1_addr,
  input  logic [4:0]                    rs2_addr,
  output logic                          hazard,
  output logic                          wreg,
  output logic [4:0]                    rd_addr,
  output logic [31:0]                   rd_data,
  output logic [31:0]                   pending,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [4:0]    mem_addr_q [FIFO_DEPTH];
  logic [31:0]   mem_data_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          wreg_q, wreg_d;
  logic [4:0]    rd_addr_q, rd_addr_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          src_long_q, src_long_d;
  logic [31:0]   pending_q, pending_d;
  logic          full, empty, push, pop, take_alu;

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign push     = lsu_valid & ~full;
  // A full FIFO always wins the port so completions cannot starve behind the ALU.
  assign pop      = full | (~alu_valid & ~empty);
  assign take_alu = alu_valid & ~full;
  assign count_d  = count_q + CW'(push) - CW'(pop);

  always_comb begin
    wreg_d     = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    src_long_d = 1'b0;
    if (pop) begin
      wreg_d     = (mem_addr_q[rd_ptr_q] != 5'd0);
      rd_addr_d  = mem_addr_q[rd_ptr_q];
      rd_data_d  = mem_data_q[rd_ptr_q];
      src_long_d = 1'b1;
    end else if (take_alu) begin
      wreg_d     = (alu_rd_addr != 5'd0);
      rd_addr_d  = alu_rd_addr;
      rd_data_d  = alu_rd_data;
    end
  end

  // Clear on the committing write first so a same-edge re-issue keeps the bit set.
  always_comb begin
    pending_d = pending_q;
    if (wreg_q & src_long_q)
      pending_d[rd_addr_q] = 1'b0;
    if (issue_valid & issue_long & (issue_rd_addr != 5'd0))
      pending_d[issue_rd_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wreg_q     <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      src_long_q <= 1'b0;
      pending_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q    <= count_d;
      wreg_q     <= wreg_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      src_long_q <= src_long_d;
      pending_q  <= pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= lsu_rd_addr;
      mem_data_q[wr_ptr_q] <= lsu_rd_data;
    end
  end

  assign alu_ready  = ~full;
  assign lsu_ready  = ~full;
  assign hazard     = pending_q[rs1_addr] | pending_q[rs2_addr] |
                      (issue_valid & pending_q[issue_rd_addr]);
  assign wreg       = wreg_q;
  assign rd_addr    = rd_addr_q;
  assign rd_data    = rd_data_q;
  assign pending    = pending_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Bench for core_wb_arbiter: directed scenarios plus random traffic against a
// queue-based reference model of the write port and scoreboard.
module tb_core_wb_arbiter;
  localparam int D  = 2;
  localparam int CW = $clog2(D) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic alu_valid = 0, lsu_valid = 0, issue_valid = 0, issue_long = 0;
  logic [4:0] alu_rd_addr = 0, lsu_rd_addr = 0, issue_rd_addr = 0, rs1_addr = 0, rs2_addr = 0;
  logic [31:0] alu_rd_data = 0, lsu_rd_data = 0;
  logic alu_ready, lsu_ready, hazard, wreg;
  logic [4:0] rd_addr;
  logic [31:0] rd_data, pending;
  logic [CW-1:0] fifo_count;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [4:0]  mq_addr[$];
  logic [31:0] mq_data[$];
  logic        m_wreg, m_src;
  logic [4:0]  m_rd_addr;
  logic [31:0] m_rd_data;
  logic [31:0] m_pend;

  core_wb_arbiter #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd_addr(alu_rd_addr), .alu_rd_data(alu_rd_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd_addr(lsu_rd_addr), .lsu_rd_data(lsu_rd_data),
    .issue_valid(issue_valid), .issue_long(issue_long), .issue_rd_addr(issue_rd_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .hazard(hazard),
    .wreg(wreg), .rd_addr(rd_addr), .rd_data(rd_data), .pending(pending), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic m_hazard();
    logic h;
    h = (rs1_addr != 0 && m_pend[rs1_addr]) || (rs2_addr != 0 && m_pend[rs2_addr]) ||
        (issue_valid && issue_rd_addr != 0 && m_pend[issue_rd_addr]);
    return h;
  endfunction

  task automatic model_reset();
    mq_addr.delete(); mq_data.delete();
    m_wreg = 0; m_src = 0; m_rd_addr = 0; m_rd_data = 0; m_pend = 0;
  endtask

  task automatic model_next();
    logic [31:0] np;
    logic full, pushing;
    if (rst) begin
      model_reset();
    end else begin
      full = (mq_addr.size() == D);
      np = m_pend;
      if (m_wreg && m_src) np[m_rd_addr] = 1'b0;
      if (issue_valid && issue_long && issue_rd_addr != 0) np[issue_rd_addr] = 1'b1;
      pushing = lsu_valid && !full;
      if (full || (!alu_valid && mq_addr.size() > 0)) begin
        m_rd_addr = mq_addr.pop_front();
        m_rd_data = mq_data.pop_front();
        m_wreg = (m_rd_addr != 0);
        m_src = 1;
      end else if (alu_valid) begin
        m_rd_addr = alu_rd_addr;
        m_rd_data = alu_rd_data;
        m_wreg = (alu_rd_addr != 0);
        m_src = 0;
      end else begin
        m_wreg = 0;
        m_src = 0;
      end
      if (pushing) begin
        mq_addr.push_back(lsu_rd_addr);
        mq_data.push_back(lsu_rd_data);
      end
      m_pend = np;
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 0; lsu_valid = 0; issue_valid = 0; issue_long = 0;
    alu_rd_addr = 0; lsu_rd_addr = 0; issue_rd_addr = 0; rs1_addr = 0; rs2_addr = 0;
    alu_rd_data = 0; lsu_rd_data = 0;
  endtask

  task automatic advance();
    model_next();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1; model_reset();
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 6; c++) begin
      alu_valid = 1; alu_rd_addr = 5'(c + 1); alu_rd_data = $urandom;
      lsu_valid = 1; lsu_rd_addr = 5'(c + 3); lsu_rd_data = $urandom;
      issue_valid = 1; issue_long = 1; issue_rd_addr = 5'(c + 8);
      advance();
    end
    rst = 1; model_reset();
    @(negedge clk);
    total++; if (wreg !== 1'b0) begin bad++; $display("FAIL reset_wreg: got %0h want 0", wreg); end
    total++; if (rd_addr !== 5'd0) begin bad++; $display("FAIL reset_rd_addr: got %0h want 0", rd_addr); end
    total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL reset_rd_data: got %0h want 0", rd_data); end
    total++; if (pending !== 32'd0) begin bad++; $display("FAIL reset_pending: got %0h want 0", pending); end
    total++; if (fifo_count !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    total++; if (lsu_ready !== 1'b1 || alu_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got alu=%0b lsu=%0b want 1 1", alu_ready, lsu_ready); end
    advance();
    rst = 0;
    idle_inputs();
  endtask

  task automatic test_alu_single();
    apply_reset();
    alu_valid = 1; alu_rd_addr = 5; alu_rd_data = 32'hDEADBEEF;
    advance();
    alu_rd_addr = 0; alu_rd_data = 32'h55;
    total++; if (wreg !== 1'b1 || rd_addr !== 5'd5 || rd_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL alu_write: got w=%0b a=%0d d=%0h want 1 5 deadbeef", wreg, rd_addr, rd_data); end
    advance();
    alu_valid = 0;
    total++; if (wreg !== 1'b0) begin bad++; $display("FAIL alu_x0: got wreg=%0b want 0", wreg); end
    advance();
  endtask

  task automatic test_long_roundtrip();
    apply_reset();
    issue_valid = 1; issue_long = 1; issue_rd_addr = 7;
    advance();
    issue_valid = 0; issue_long = 0; rs1_addr = 7;
    @(negedge clk);
    total++; if (pending[7] !== 1'b1) begin bad++; $display("FAIL rt_pending_set: got %0b want 1", pending[7]); end
    total++; if (hazard !== 1'b1) begin bad++; $display("FAIL rt_raw_hazard: got %0b want 1", hazard); end
    lsu_valid = 1; lsu_rd_addr = 7; lsu_rd_data = 32'h12345678;
    advance();
    lsu_valid = 0;
    total++; if (fifo_count !== CW'(1) || wreg !== 1'b0) begin
      bad++; $display("FAIL rt_accept: got count=%0d w=%0b want 1 0", fifo_count, wreg); end
    advance();
    total++; if (wreg !== 1'b1 || rd_addr !== 5'd7 || rd_data !== 32'h12345678 || pending[7] !== 1'b1) begin
      bad++; $display("FAIL rt_write: got w=%0b a=%0d d=%0h p=%0b want 1 7 12345678 1", wreg, rd_addr, rd_data, pending[7]); end
    advance();
    @(negedge clk);
    total++; if (pending[7] !== 1'b0 || hazard !== 1'b0) begin
      bad++; $display("FAIL rt_clear: got p=%0b h=%0b want 0 0", pending[7], hazard); end
    rs1_addr = 0;
  endtask

  task automatic test_full_fifo();
    logic [4:0] got[$];
    int idx;
    int fullcyc;
    idx = 0; fullcyc = 0;
    apply_reset();
    alu_valid = 1; alu_rd_addr = 10; alu_rd_data = 32'hA1A1A1A1;
    for (int c = 0; c < 16; c++) begin
      if (c == 10) alu_valid = 0;
      lsu_valid = (idx < 3);
      lsu_rd_addr = 5'(idx + 1);
      lsu_rd_data = 32'h100 + 32'(idx);
      @(negedge clk);
      if (mq_addr.size() == D) begin
        fullcyc++;
        total++; if (lsu_ready !== 1'b0 || alu_ready !== 1'b0) begin
          bad++; $display("FAIL full_ready c%0d: got alu=%0b lsu=%0b want 0 0", c, alu_ready, lsu_ready); end
      end
      if (wreg === 1'b1 && rd_addr !== 5'd10) begin
        got.push_back(rd_addr);
        total++; if (rd_data !== 32'h100 + 32'(rd_addr) - 32'd1) begin
          bad++; $display("FAIL full_data: got %0h want %0h", rd_data, 32'h100 + 32'(rd_addr) - 32'd1); end
      end
      if (lsu_valid && lsu_ready) idx++;
      advance();
    end
    total++; if (fullcyc < 2) begin bad++; $display("FAIL full_reached: got %0d full cycles want >=2", fullcyc); end
    total++; if (got.size() != 3) begin
      bad++; $display("FAIL full_count: got %0d writes want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++; if (got[i] !== 5'(i + 1)) begin bad++; $display("FAIL full_order[%0d]: got %0d want %0d", i, got[i], i + 1); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_set_clear();
    apply_reset();
    issue_valid = 1; issue_long = 1; issue_rd_addr = 9;
    advance();
    issue_valid = 0; issue_long = 0;
    lsu_valid = 1; lsu_rd_addr = 9; lsu_rd_data = 32'hCAFE0009;
    advance();
    lsu_valid = 0;
    advance();
    issue_valid = 1; issue_long = 1; issue_rd_addr = 9;
    @(negedge clk);
    total++; if (wreg !== 1'b1 || rd_addr !== 5'd9) begin
      bad++; $display("FAIL sc_commit: got w=%0b a=%0d want 1 9", wreg, rd_addr); end
    advance();
    issue_valid = 0; issue_long = 0;
    @(negedge clk);
    total++; if (pending[9] !== 1'b1) begin bad++; $display("FAIL sc_set_wins: got %0b want 1", pending[9]); end
  endtask

  task automatic test_waw();
    apply_reset();
    issue_valid = 1; issue_long = 1; issue_rd_addr = 4;
    advance();
    issue_long = 0; issue_rd_addr = 4;
    @(negedge clk);
    total++; if (hazard !== 1'b1) begin bad++; $display("FAIL waw_hazard: got %0b want 1", hazard); end
    issue_valid = 0;
    #1;
    total++; if (hazard !== 1'b0) begin bad++; $display("FAIL waw_no_issue: got %0b want 0", hazard); end
    issue_valid = 1; issue_long = 1; issue_rd_addr = 0;
    advance();
    issue_valid = 0; issue_long = 0;
    @(negedge clk);
    total++; if (pending !== 32'h10) begin bad++; $display("FAIL waw_x0_set: got %0h want 10", pending); end
  endtask

  task automatic test_random();
    logic keep_alu;
    keep_alu = 0;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if (!keep_alu) begin
        alu_valid = ($urandom_range(0, 99) < 60);
        alu_rd_addr = 5'($urandom_range(0, 7));
        alu_rd_data = $urandom;
      end
      lsu_valid = ($urandom_range(0, 99) < 45);
      lsu_rd_addr = 5'($urandom_range(0, 7));
      lsu_rd_data = $urandom;
      issue_valid = ($urandom_range(0, 99) < 30);
      issue_long = $urandom_range(0, 1);
      issue_rd_addr = 5'($urandom_range(0, 7));
      rs1_addr = 5'($urandom_range(0, 7));
      rs2_addr = 5'($urandom_range(0, 7));
      @(negedge clk);
      total++; if (alu_ready !== (mq_addr.size() != D) || lsu_ready !== (mq_addr.size() != D)) begin
        bad++; $display("FAIL rnd_ready c%0d: got alu=%0b lsu=%0b want %0b", c, alu_ready, lsu_ready, mq_addr.size() != D); end
      total++; if (fifo_count !== CW'(mq_addr.size())) begin
        bad++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, fifo_count, mq_addr.size()); end
      total++; if (pending !== m_pend) begin
        bad++; $display("FAIL rnd_pending c%0d: got %0h want %0h", c, pending, m_pend); end
      total++; if (hazard !== m_hazard()) begin
        bad++; $display("FAIL rnd_hazard c%0d: got %0b want %0b", c, hazard, m_hazard()); end
      total++; if (wreg !== m_wreg) begin
        bad++; $display("FAIL rnd_wreg c%0d: got %0b want %0b", c, wreg, m_wreg); end
      if (m_wreg) begin
        total++; if (rd_addr !== m_rd_addr || rd_data !== m_rd_data) begin
          bad++; $display("FAIL rnd_write c%0d: got %0d/%0h want %0d/%0h", c, rd_addr, rd_data, m_rd_addr, m_rd_data); end
      end
      keep_alu = alu_valid && (mq_addr.size() == D);
      advance();
    end
    idle_inputs();
  endtask

  initial begin
    model_reset();
    apply_reset();
    test_reset();
    test_alu_single();
    test_long_roundtrip();
    test_full_fifo();
    test_set_clear();
    test_waw();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
